// File: rtl/wash_seq_ctrl_if.sv
// Front-panel / motor-driver bundle for the wash sequencer.
// Start handshake: start is sampled together with reps and mode only while busy is low; no ready is returned.
interface wash_seq_ctrl_if #(
    parameter int RW = 4
);
    logic          start;
    logic [RW-1:0] reps;
    logic          mode;
    logic          hold;
    logic          abort;
    logic [1:0]    motor;
    logic          busy;
    logic          done;
    logic [RW-1:0] reps_left;
    logic [2:0]    phase;

    modport master (
        output start, reps, mode, hold, abort,
        input  motor, busy, done, reps_left, phase
    );

    modport slave (
        input  start, reps, mode, hold, abort,
        output motor, busy, done, reps_left, phase
    );
endinterface

// File: rtl/wash_seq_ctrl.sv
// Wash motor sequencer: repeats CW/PAUSE[/CCW/PAUSE] with an internal phase timer,
// supporting hold (freeze), abort and a one-cycle done pulse.
module wash_seq_ctrl #(
    parameter int TW          = 8,
    parameter int CW_TICKS    = 20,
    parameter int CCW_TICKS   = 20,
    parameter int PAUSE_TICKS = 10,
    parameter int RW          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    wash_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CW   = 3'd1,
        P1   = 3'd2,
        CCW  = 3'd3,
        P2   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [TW-1:0] last_tick;
    logic [RW-1:0] reps_left_q, reps_n;
    logic          mode_q, mode_n;
    logic          done_q, done_n;
    logic          rep_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            reps_left_q <= '0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            reps_left_q <= reps_n;
            mode_q      <= mode_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        last_tick = TW'(PAUSE_TICKS - 1);
        case (state)
            CW:      last_tick = TW'(CW_TICKS - 1);
            CCW:     last_tick = TW'(CCW_TICKS - 1);
            default: last_tick = TW'(PAUSE_TICKS - 1);
        endcase
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        reps_n  = reps_left_q;
        mode_n  = mode_q;
        done_n  = 1'b0;
        rep_end = 1'b0;
        case (state)
            IDLE: begin
                // abort in IDLE suppresses a simultaneous start
                if (bus.start && !bus.abort && bus.reps != '0) begin
                    state_n = CW;
                    timer_n = '0;
                    reps_n  = bus.reps;
                    mode_n  = bus.mode;
                end
            end
            CW, P1, CCW, P2: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    timer_n = '0;
                    reps_n  = '0;
                end else if (!bus.hold) begin
                    if (timer == last_tick) begin
                        timer_n = '0;
                        case (state)
                            CW:      state_n = P1;
                            P1:      if (mode_q) rep_end = 1'b1; else state_n = CCW;
                            CCW:     state_n = P2;
                            default: rep_end = 1'b1;
                        endcase
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
                reps_n  = '0;
            end
        endcase

        if (rep_end) begin
            if (reps_left_q == RW'(1)) begin
                state_n = IDLE;
                reps_n  = '0;
                done_n  = 1'b1;
            end else begin
                state_n = CW;
                reps_n  = reps_left_q - 1'b1;
            end
        end
    end

    // Motor is gated by hold combinationally so a pause stops the drum in the same cycle.
    always_comb begin
        bus.motor = 2'd0;
        if (!bus.hold) begin
            case (state)
                CW:      bus.motor = 2'd1;
                CCW:     bus.motor = 2'd2;
                default: bus.motor = 2'd0;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.reps_left = reps_left_q;
    assign bus.phase     = state;
endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Bench for wash_seq_ctrl: a segment-list reference model feeds an expected queue
// that a negedge monitor drains against the DUT outputs each cycle.
module tb_wash_seq_ctrl;
    localparam int CW_T  = 4;
    localparam int CCW_T = 3;
    localparam int P_T   = 2;
    localparam int RW    = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   fails    = 0;
    int   busy_cnt = 0;

    wash_seq_ctrl_if #(.RW(RW)) bus ();

    wash_seq_ctrl #(
        .TW(8), .CW_TICKS(CW_T), .CCW_TICKS(CCW_T), .PAUSE_TICKS(P_T), .RW(RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the remaining run is a list of (phase code, length, reps_left) segments.
    typedef struct {
        logic [2:0]    code;
        int            len;
        logic [RW-1:0] rl;
    } seg_t;

    seg_t          seg_q[$];
    int            elapsed   = 0;
    bit            done_flag = 1'b0;
    logic [10:0]   exp_q[$];

    task automatic build_run(input logic [RW-1:0] n, input logic md);
        seg_t s;
        for (int r = int'(n); r >= 1; r--) begin
            s.rl = RW'(r);
            s.code = 3'd1; s.len = CW_T; seg_q.push_back(s);
            s.code = 3'd2; s.len = P_T;  seg_q.push_back(s);
            if (!md) begin
                s.code = 3'd3; s.len = CCW_T; seg_q.push_back(s);
                s.code = 3'd4; s.len = P_T;   seg_q.push_back(s);
            end
        end
    endtask

    task automatic model_step();
        logic [10:0] e;
        logic [1:0]  mot;
        if (!rst_n) begin
            e = '0;
        end else if (seg_q.size() == 0) begin
            e = {2'd0, 1'b0, done_flag, 4'd0, 3'd0};
        end else begin
            mot = 2'd0;
            if (!bus.hold && seg_q[0].code == 3'd1) mot = 2'd1;
            if (!bus.hold && seg_q[0].code == 3'd3) mot = 2'd2;
            e = {mot, 1'b1, 1'b0, seg_q[0].rl, seg_q[0].code};
        end
        exp_q.push_back(e);

        done_flag = 1'b0;
        if (!rst_n) begin
            seg_q.delete();
            elapsed = 0;
        end else if (seg_q.size() == 0) begin
            elapsed = 0;
            if (bus.start && !bus.abort && bus.reps != '0) build_run(bus.reps, bus.mode);
        end else if (bus.abort) begin
            seg_q.delete();
            elapsed = 0;
        end else if (!bus.hold) begin
            elapsed++;
            if (elapsed == seg_q[0].len) begin
                void'(seg_q.pop_front());
                elapsed = 0;
                if (seg_q.size() == 0) done_flag = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic st, input logic [RW-1:0] rp, input logic md,
                        input logic hd, input logic ab);
        @(posedge clk);
        #1;
        bus.start = st;
        bus.reps  = rp;
        bus.mode  = md;
        bus.hold  = hd;
        bus.abort = ab;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_motor", int'(bus.motor), 0);
        check_val("async_busy", int'(bus.busy), 0);
        check_val("async_done", int'(bus.done), 0);
        check_val("async_reps_left", int'(bus.reps_left), 0);
        model_step();
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        logic [10:0] a;
        if (bus.busy) busy_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.motor, bus.busy, bus.done, bus.reps_left, bus.phase};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_out @%0t: got motor=%0d busy=%0d done=%0d reps_left=%0d phase=%0d, expected motor=%0d busy=%0d done=%0d reps_left=%0d phase=%0d",
                         $time, a[10:9], a[8], a[7], a[6:3], a[2:0],
                         e[10:9], e[8], e[7], e[6:3], e[2:0]);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.reps  = '0;
        bus.mode  = 1'b0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Single bidirectional repetition
        busy_cnt = 0;
        tick(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(14);
        check_val("busy_rep1_mode0", busy_cnt, 1 * (CW_T + CCW_T + 2 * P_T));

        // Three CW-only repetitions
        busy_cnt = 0;
        tick(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        idle(22);
        check_val("busy_rep3_mode1", busy_cnt, 3 * (CW_T + P_T));

        // Hold for 5 cycles from the 2nd CW cycle
        busy_cnt = 0;
        tick(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(30);
        check_val("busy_hold", busy_cnt, 2 * (CW_T + CCW_T + 2 * P_T) + 5);

        // Abort in CCW of repetition 2, then a normal run
        busy_cnt = 0;
        tick(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle(18);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_val("busy_abort", busy_cnt, 19);
        busy_cnt = 0;
        tick(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(14);
        check_val("busy_after_abort", busy_cnt, 11);

        // Ignored starts: reps=0, and abort together with start
        busy_cnt = 0;
        tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        tick(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_val("busy_ignored_start", busy_cnt, 0);

        // Start pulses while busy do not disturb the run
        busy_cnt = 0;
        tick(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        idle(2);
        tick(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        idle(3);
        tick(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        idle(10);
        check_val("busy_restart_ignored", busy_cnt, 2 * (CW_T + P_T));

        // Asynchronous reset in the middle of P1
        busy_cnt = 0;
        tick(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        idle(5);
        async_reset_check();
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check_val("busy_before_reset", busy_cnt, CW_T + 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 9) == 0), RW'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 79) == 0));
        end
        idle(100);

        @(posedge clk);
        #1;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
